// File: rtl/text_overlay_gen.sv
// -----------------------------------------------------------------------------
// text_overlay_gen
//
// Text-mode character generator for the VGA path. Each pixel position from the
// timing generator is mapped to a character cell. The cell's code and
// attribute are fetched from an external text RAM, and the glyph is fetched
// from an external font memory. The result is an RGB565 pixel. Each cell has
// its own fg/bg colour and invert bit, and a blinking hardware cursor can be
// overlaid on one cell.
//
// Pipeline (T = edge where the counters are sampled):
//   T   : cell/offset decode, text_addr registered
//   T+1 : text RAM presents text_data
//   T+2 : font_addr and attributes registered from text_data
//   T+3 : glyph bit selected, colour resolved, Red/Green/Blue registered
//
// Ports:
//   clock50            system clock, rising edge
//   reset              synchronous active-high reset
//   HorizontalCounter  pixel column from the timing generator
//   VerticalCounter    line from the timing generator
//   text_addr          text RAM read address (row*COLS + col), 0 outside text
//   text_data          text RAM data, 1-cycle latency
//                      [6:0] code, [7] invert, [10:8] fg, [13:11] bg
//   font_addr          glyph index to the font memory
//   font_data          glyph bitmap; row y at [y*GLYPH_W +: GLYPH_W], MSB leftmost
//   cursor_en          cursor enable
//   cursor_col/row     cursor cell position
//   Red/Green/Blue     registered RGB565 pixel
// -----------------------------------------------------------------------------
module text_overlay_gen #(
  parameter int GLYPH_W      = 8,
  parameter int GLYPH_H      = 12,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int COLS         = 80,
  parameter int ROWS         = 40,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                              clock50,
  input  logic                              reset,
  input  logic [9:0]                        HorizontalCounter,
  input  logic [9:0]                        VerticalCounter,
  output logic [$clog2(COLS*ROWS)-1:0]      text_addr,
  input  logic [15:0]                       text_data,
  output logic [6:0]                        font_addr,
  input  logic [GLYPH_W*GLYPH_H-1:0]        font_data,
  input  logic                              cursor_en,
  input  logic [6:0]                        cursor_col,
  input  logic [5:0]                        cursor_row,
  output logic [4:0]                        Red,
  output logic [5:0]                        Green,
  output logic [4:0]                        Blue
);

  localparam int ADDR_W = $clog2(COLS*ROWS);
  localparam int XW     = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int YW     = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int BW     = $clog2(GLYPH_W*GLYPH_H);
  localparam int FW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Per-pixel context that travels alongside the RAM/font fetches.
  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          in_text;
    logic          cursor_hit;
  } pix_t;

  // Stage 1 decode
  logic [9:0]        col_d;
  logic [9:0]        row_d;
  logic [ADDR_W-1:0] addr_d;
  pix_t              s1_d;
  logic              at_origin;
  logic              frame_start;

  // Pipeline state
  logic [ADDR_W-1:0] addr_q;
  pix_t              s1_q, s2_q, s3_q;
  logic [6:0]        font_addr_q;
  logic              inv_q;
  logic [2:0]        fg_q;
  logic [2:0]        bg_q;
  logic [4:0]        red_q;
  logic [5:0]        green_q;
  logic [4:0]        blue_q;

  // Frame / blink state
  logic              origin_q;
  logic [FW-1:0]     frame_cnt_q;
  logic              blink_phase_q;

  // Stage 4 decode
  logic [BW-1:0]     bit_idx;
  logic              pix_on;
  logic [2:0]        colour;

  // The two top attribute bits carry no meaning here.
  logic              unused_text_bits;
  assign unused_text_bits = ^text_data[15:14];

  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (here unconditionally), otherwise synthesis infers a latch.
  always_comb begin
    col_d        = HorizontalCounter / 10'(GLYPH_W);
    row_d        = VerticalCounter / 10'(GLYPH_H);
    s1_d.x       = XW'(HorizontalCounter % 10'(GLYPH_W));
    s1_d.y       = YW'(VerticalCounter % 10'(GLYPH_H));
    s1_d.in_text = (int'(HorizontalCounter) < COLS*GLYPH_W) &&
                   (int'(VerticalCounter)   < ROWS*GLYPH_H) &&
                   (int'(HorizontalCounter) < H_ACTIVE)     &&
                   (int'(VerticalCounter)   < V_ACTIVE);
    // An out-of-range cursor position can never match an in-text cell.
    s1_d.cursor_hit = cursor_en && blink_phase_q && s1_d.in_text &&
                      (col_d == 10'(cursor_col)) && (row_d == 10'(cursor_row));
    addr_d = s1_d.in_text ? (ADDR_W'(row_d) * ADDR_W'(COLS) + ADDR_W'(col_d))
                          : '0;

    // Frame start fires once on entry to (0,0), even if the counters dwell there.
    at_origin   = (HorizontalCounter == 10'd0) && (VerticalCounter == 10'd0);
    frame_start = at_origin && !origin_q;
  end

  always_comb begin
    // x = 0 is the leftmost pixel, which is the MSB of the row slice.
    bit_idx = BW'(s3_q.y) * BW'(GLYPH_W) + BW'(GLYPH_W - 1) - BW'(s3_q.x);
    pix_on  = font_data[bit_idx] ^ inv_q ^ s3_q.cursor_hit;
    colour  = pix_on ? fg_q : bg_q;
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // stage reads the previous stage's value from before this edge.
  always_ff @(posedge clock50) begin
    if (reset) begin
      addr_q        <= '0;
      s1_q          <= '0;
      s2_q          <= '0;
      s3_q          <= '0;
      font_addr_q   <= '0;
      inv_q         <= 1'b0;
      fg_q          <= '0;
      bg_q          <= '0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      origin_q      <= 1'b0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      origin_q <= at_origin;
      // The new phase applies to pixels sampled from the next edge on;
      // pixels already in flight keep the cursor_hit they were sampled with.
      if (frame_start) begin
        if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt_q   <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          frame_cnt_q <= frame_cnt_q + FW'(1);
        end
      end

      // Stage 1
      addr_q <= addr_d;
      s1_q   <= s1_d;
      // Stage 2: the RAM works on addr_q this cycle
      s2_q   <= s1_q;
      // Stage 3: capture the cell's code and attributes
      s3_q        <= s2_q;
      font_addr_q <= text_data[6:0];
      inv_q       <= text_data[7];
      fg_q        <= text_data[10:8];
      bg_q        <= text_data[13:11];
      // Stage 4: resolve the pixel
      red_q   <= s3_q.in_text ? {5{colour[0]}} : 5'd0;
      green_q <= s3_q.in_text ? {6{colour[1]}} : 6'd0;
      blue_q  <= s3_q.in_text ? {5{colour[2]}} : 5'd0;
    end
  end

  assign text_addr = addr_q;
  assign font_addr = font_addr_q;
  assign Red       = red_q;
  assign Green     = green_q;
  assign Blue      = blue_q;

endmodule

// File: tb/tb_text_overlay_gen.sv
// -----------------------------------------------------------------------------
// tb_text_overlay_gen
//
// Directed bench for text_overlay_gen. A behavioural text RAM (1-cycle read)
// and a combinational font ROM surround the DUT. Expected pixels come from the
// bench's own '$' bitmap, attribute decoding and blink model.
// -----------------------------------------------------------------------------
module tb_text_overlay_gen;

  logic        clock50 = 1'b0;
  logic        reset;
  logic [9:0]  HorizontalCounter;
  logic [9:0]  VerticalCounter;
  logic [11:0] text_addr;
  logic [15:0] text_data;
  logic [6:0]  font_addr;
  logic [95:0] font_data;
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic [4:0]  Red;
  logic [5:0]  Green;
  logic [4:0]  Blue;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] ram [0:4095];
  logic [7:0]  dollar_rows [0:11];
  logic [95:0] dollar_bmp;
  logic        glyph_ones;

  // Bench blink model
  int   model_cnt;
  logic model_phase;

  text_overlay_gen #(.BLINK_FRAMES(2)) dut (
    .clock50           (clock50),
    .reset             (reset),
    .HorizontalCounter (HorizontalCounter),
    .VerticalCounter   (VerticalCounter),
    .text_addr         (text_addr),
    .text_data         (text_data),
    .font_addr         (font_addr),
    .font_data         (font_data),
    .cursor_en         (cursor_en),
    .cursor_col        (cursor_col),
    .cursor_row        (cursor_row),
    .Red               (Red),
    .Green             (Green),
    .Blue              (Blue)
  );

  always #5 clock50 = ~clock50;

  always @(posedge clock50) text_data <= ram[text_addr];

  always_comb begin
    font_data = '0;
    if (font_addr == 7'h24)      font_data = dollar_bmp;
    else if (font_addr == 7'h1F) font_data = glyph_ones ? {96{1'b1}} : 96'd0;
  end

  task automatic tick();
    @(posedge clock50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rgb();
    return {Red, Green, Blue};
  endfunction

  // Hold a pixel long enough for it to reach the outputs (sample + 3 clocks).
  task automatic show(input int h, input int v);
    HorizontalCounter = 10'(h);
    VerticalCounter   = 10'(v);
    repeat (4) tick();
  endtask

  task automatic frame_start();
    HorizontalCounter = 10'd0;
    VerticalCounter   = 10'd0;
    repeat (2) tick();
    model_cnt++;
    if (model_cnt == 2) begin
      model_cnt   = 0;
      model_phase = ~model_phase;
    end
  endtask

  logic [15:0] exp_px;
  logic [7:0]  row_bits;

  initial begin
    dollar_rows[0]  = 8'h10; dollar_rows[1]  = 8'h7C; dollar_rows[2]  = 8'hD6;
    dollar_rows[3]  = 8'hD0; dollar_rows[4]  = 8'hD0; dollar_rows[5]  = 8'h7C;
    dollar_rows[6]  = 8'h16; dollar_rows[7]  = 8'h16; dollar_rows[8]  = 8'hD6;
    dollar_rows[9]  = 8'h7C; dollar_rows[10] = 8'h10; dollar_rows[11] = 8'h00;
    for (int y = 0; y < 12; y++) dollar_bmp[y*8 +: 8] = dollar_rows[y];
    for (int a = 0; a < 4096; a++) ram[a] = 16'h0000;
    ram[0]   = 16'h0724;   // '$', fg 7, bg 0
    ram[1]   = 16'h0C9F;   // code 0x1F, inv, fg 4, bg 1
    ram[163] = 16'h0700;   // cursor cell (3,2): blank glyph, fg 7, bg 0
    glyph_ones  = 1'b1;
    model_cnt   = 0;
    model_phase = 1'b0;

    reset             = 1'b1;
    HorizontalCounter = 10'd700;
    VerticalCounter   = 10'd500;
    cursor_en         = 1'b0;
    cursor_col        = 7'd3;
    cursor_row        = 6'd2;
    repeat (3) tick();
    check("reset_rgb",       32'(rgb()),     32'h0);
    check("reset_text_addr", 32'(text_addr), 32'h0);
    check("reset_font_addr", 32'(font_addr), 32'h0);
    reset = 1'b0;

    // '$' cell streamed at one pixel per clock; each output 3 clocks after its sample.
    for (int i = 0; i < 99; i++) begin
      if (i < 96) begin
        HorizontalCounter = 10'(i % 8);
        VerticalCounter   = 10'(i / 8);
      end
      tick();
      if (i >= 3) begin
        row_bits = dollar_rows[(i-3) / 8];
        exp_px   = row_bits[7 - ((i-3) % 8)] ? 16'hFFFF : 16'h0000;
        check($sformatf("dollar_px%0d", i-3), 32'(rgb()), 32'(exp_px));
      end
    end
    model_cnt = 1;   // the sweep began with one frame start
    check("frame_cnt_after_sweep", 32'(dut.frame_cnt_q), 32'(model_cnt));

    // Inverted cell: full glyph shows bg (1 = red), empty glyph shows fg (4 = blue).
    show(8, 0);   check("inv_ones_a",  32'(rgb()), 32'hF800);
    show(11, 5);  check("inv_ones_b",  32'(rgb()), 32'hF800);
    show(15, 11); check("inv_ones_c",  32'(rgb()), 32'hF800);
    glyph_ones = 1'b0;
    show(8, 0);   check("inv_zeros_a", 32'(rgb()), 32'h001F);
    show(13, 7);  check("inv_zeros_b", 32'(rgb()), 32'h001F);

    // Address mapping and out-of-area behaviour.
    HorizontalCounter = 10'd100;
    VerticalCounter   = 10'd50;
    tick();
    check("addr_100_50", 32'(text_addr), 32'd332);
    show(645, 10); check("h645_rgb",  32'(rgb()), 32'h0);
    check("h645_addr", 32'(text_addr), 32'h0);
    show(10, 485); check("v485_rgb",  32'(rgb()), 32'h0);
    check("v485_addr", 32'(text_addr), 32'h0);

    // One-clock reset in the middle of a line.
    show(1, 1);
    check("pre_reset_px", 32'(rgb()), 32'hFFFF);
    reset = 1'b1;
    tick();
    check("reset_mid_rgb",   32'(rgb()), 32'h0);
    check("reset_mid_fcnt",  32'(dut.frame_cnt_q), 32'h0);
    check("reset_mid_blink", 32'(dut.blink_phase_q), 32'h0);
    reset       = 1'b0;
    model_cnt   = 0;
    model_phase = 1'b0;
    tick(); check("resume_t1", 32'(rgb()), 32'h0);
    tick(); check("resume_t2", 32'(rgb()), 32'h0);
    tick(); check("resume_t3", 32'(rgb()), 32'h0);
    tick(); check("resume_t4", 32'(rgb()), 32'hFFFF);

    // Cursor blink across 5 frames with BLINK_FRAMES = 2.
    cursor_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      frame_start();
      check($sformatf("blink_phase_f%0d", k), 32'(dut.blink_phase_q), 32'(model_phase));
      show(24, 24);
      check($sformatf("cursor_px_f%0d", k), 32'(rgb()), model_phase ? 32'hFFFF : 32'h0);
      show(32, 24);
      check($sformatf("next_cell_f%0d", k), 32'(rgb()), 32'h0);
      if (k == 3) begin
        cursor_en = 1'b0;
        show(24, 24); check("cursor_disabled", 32'(rgb()), 32'h0);
        cursor_en  = 1'b1;
        cursor_col = 7'd100;
        show(24, 24); check("cursor_col_oor", 32'(rgb()), 32'h0);
        cursor_col = 7'd3;
        show(24, 24); check("cursor_restored", 32'(rgb()), 32'hFFFF);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/text_overlay_gen.md
# text_overlay_gen

Parametrised text-mode character generator for the VGA path: maps the pixel position (HorizontalCounter, VerticalCounter) to a character cell, fetches the cell's code and attribute from an external text RAM, fetches the glyph from the external font memory, and drives RGB565 pixels. It adds configurable glyph geometry, per-cell foreground/background colour, per-cell inversion and a blinking hardware cursor. It sits between the VGA timing generator and the colour outputs, and feeds both the text RAM and the font memory.

## Interface
- GLYPH_W, 8: glyph width in pixels.
- GLYPH_H, 12: glyph height in pixels.
- H_ACTIVE, 640: visible pixels per line.
- V_ACTIVE, 480: visible lines per frame.
- COLS, 80: text columns; COLS*GLYPH_W <= H_ACTIVE.
- ROWS, 40: text rows; ROWS*GLYPH_H <= V_ACTIVE.
- BLINK_FRAMES, 30: frames per cursor blink half-period, >= 1.
- clock50  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- HorizontalCounter  in  10  current pixel column from the timing generator.
- VerticalCounter  in  10  current line from the timing generator.
- text_addr  out  clog2(COLS*ROWS)  text RAM read address = row*COLS + col.
- text_data  in  16  text RAM read data, 1-cycle latency. [6:0] char code, [7] invert, [10:8] fg colour, [13:11] bg colour, [15:14] ignored.
- font_addr  out  7  glyph index to the font memory.
- font_data  in  GLYPH_W*GLYPH_H  glyph bitmap; combinational from font_addr.
- cursor_en  in  1  cursor enable.
- cursor_col  in  7  cursor column.
- cursor_row  in  6  cursor row.
- Red  out  5  pixel red.
- Green  out  6  pixel green.
- Blue  out  5  pixel blue.

## Operation
- Stage 1 (edge T): sample counters. col = H / GLYPH_W, x = H % GLYPH_W, row = V / GLYPH_H, y = V % GLYPH_H. Register text_addr, x, y, in_text and cursor_hit. in_text = H < COLS*GLYPH_W and V < ROWS*GLYPH_H. cursor_hit = cursor_en & blink_phase & (col == cursor_col) & (row == cursor_row). When in_text = 0, text_addr holds 0.
- Stage 2 (edge T+1): the RAM presents text_data. Delay x, y, in_text and cursor_hit by one cycle.
- Stage 3 (edge T+2): register font_addr <= text_data[6:0], plus inv, fg and bg from text_data. Delay x, y, in_text and cursor_hit.
- Stage 4 (edge T+3): read pixel bit font_data[y*GLYPH_W + (GLYPH_W-1-x)]. Bit x=0 is the leftmost pixel, which is the MSB of its row slice.
  - on = bit ^ inv ^ cursor_hit.
  - colour index c = on ? fg : bg.
  - Red = {5{c[0]}}, Green = {6{c[1]}}, Blue = {5{c[2]}}.
  - If in_text = 0, RGB = 0. This covers border, blanking, and counters >= H_ACTIVE or V_ACTIVE.
- Font memory owns out-of-range codes; font_addr passes the code through unchanged.
- Frame start: sampled (H,V) == (0,0) while the previous sampled pair was not (0,0). Counters held for several clocks count once.
- Blink:
  - frame_cnt increments on each frame start.
  - On a frame start with frame_cnt == BLINK_FRAMES-1, frame_cnt <= 0 and blink_phase toggles.
  - blink_phase is the value used by cursor_hit.
- cursor_col >= COLS or cursor_row >= ROWS: cursor never shown; no error.

## Timing
- Latency is exactly 3 clocks: Red/Green/Blue registered at edge T+3 correspond to the counters sampled at edge T. Throughput is one pixel per clock; there are no stalls.
- text_addr is valid 1 clock after sampling. text_data is sampled 1 clock after text_addr. font_data is sampled 1 clock after font_addr.
- Reset values: Red/Green/Blue = 0, text_addr = 0, font_addr = 0, all pipeline valid and attribute registers = 0, frame_cnt = 0, blink_phase = 0 (cursor hidden).
- Reset mid-frame: outputs are 0 from the edge where reset is sampled high. After release, the first non-reset pixel appears 3 clocks after the first sample.
- Simultaneous frame start and blink wrap: the toggle takes effect for pixels sampled from the next edge on. Pixels already in flight keep the old phase.
- Cursor inputs are sampled at stage 1 with no resynchronisation. Changing them mid-frame affects only later pixels.

## Test plan
- Cell 0 holds 0x0724 ('$', fg 7, bg 0), all others 0x0000, and the font returns a known '$' bitmap. Sweep H 0..7, V 0..11. Required: RGB = (31,63,31) exactly where the bitmap bit is 1, else (0,0,0), each pixel 3 clocks after its counter sample.
- text_data = 0x0C9F with the glyph row all ones (inv=1, fg 4, bg 1). Required: RGB = (31,0,0) on every pixel of the cell; with the glyph all zeros, RGB = (0,0,31).
- H = 100, V = 50. Required: text_addr = 4*80 + 12 = 332 one clock later. H = 645 or V = 485: RGB = 0 and text_addr = 0.
- cursor_en = 1, cursor (3,2), BLINK_FRAMES = 2, counters held 2 clocks per pixel across 5 frames. Required: blink_phase toggles at frame starts 2 and 4 only, and the cell at (3,2) is inverted only while blink_phase = 1.
- Assert reset for 1 clock mid-line. Required: RGB = 0 from that edge, frame_cnt = 0, blink_phase = 0, and the correct pixel resumes exactly 3 clocks after release.
